pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register address width.
REQ-002 SHALL have parameter NUM_SRC, default 2, source operands checked per ID instruction.
REQ-003 SHALL have parameter LOAD_LAT, default 1, extra cycles before load data is forwardable to EX.
REQ-004 SHALL have parameter BR_ALU_WAIT, default 1, cycles before an ALU result is forwardable to the ID comparator.
REQ-005 SHALL have parameter CNT_W, default 16, performance counter width.
REQ-006 SHALL use one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 id_valid  in  1  ID holds a real instruction.
REQ-009 id_src  in  NUM_SRC*REG_AW  source register numbers, src0 in LSBs.
REQ-010 id_src_used  in  NUM_SRC  per-source "operand read" flag.
REQ-011 id_is_branch  in  1  ID instruction is beq/bne (compares in ID).
REQ-012 id_br_taken  in  1  ID comparator outcome, qualified by id_is_branch.
REQ-013 id_jump  in  1  ID instruction is a jump.
REQ-014 id_reg_write, id_mem_read  in  1 each  ID instruction writes rd / is a load.
REQ-015 id_rd  in  REG_AW  ID destination register.
REQ-016 mem_stall  in  1  external memory wait; freezes whole pipeline.
REQ-017 pc_write, if_id_write  out  1 each  enable PC / IF-ID update.
REQ-018 id_ex_bubble  out  1  active-high: load NOP into ID/EX.
REQ-019 if_flush  out  1  zero IF/ID contents.
REQ-020 stall_cnt, flush_cnt  out  CNT_W each  hazard-stall cycles / flushes since reset.

Function
REQ-021 SHALL keep per register r (1..2^REG_AW-1) counters ex_wait[r], id_wait[r]; register 0 never busy.
REQ-022 Issue = id_valid & !hz_stall & !mem_stall; on issue with id_reg_write & id_rd!=0: load -> ex_wait=LOAD_LAT, id_wait=LOAD_LAT+1; non-load -> ex_wait=0, id_wait=BR_ALU_WAIT.
REQ-023 Every non-mem_stall cycle all nonzero counters decrement by 1, saturating at 0; issue load to rd overrides rd's decrement that cycle.
REQ-024 hz_stall = id_valid & any used, nonzero source s with (id_is_branch ? id_wait[s] : ex_wait[s]) != 0.
REQ-025 hz_stall & !mem_stall: pc_write=0, if_id_write=0, id_ex_bubble=1, if_flush=0, stall_cnt+1.
REQ-026 Issue with id_jump or (id_is_branch & id_br_taken): if_flush=1, pc_write=1, if_id_write=1, flush_cnt+1; branch outcome ignored while hz_stall.
REQ-027 mem_stall: pc_write=0, if_id_write=0, id_ex_bubble=0, if_flush=0; counters and scoreboard hold.
REQ-028 Otherwise: pc_write=1, if_id_write=1, id_ex_bubble=0, if_flush=0.
REQ-029 Outputs SHALL be combinational from state and inputs (zero latency); only scoreboard and counters are registered.
REQ-030 Performance counters SHALL wrap modulo 2^CNT_W.

Reset
REQ-031 rst clears all ex_wait/id_wait, stall_cnt, flush_cnt to 0 immediately, regardless of clk.
REQ-032 During reset outputs SHALL be pc_write=1, if_id_write=1, id_ex_bubble=0, if_flush=0; reset mid-stall drops the stall.

Structure
REQ-033 Parameter defaults and wait-counter width ($clog2(LOAD_LAT+2)) SHALL live in shared package pipe_hazard_pkg.
REQ-034 Scoreboard array SHALL be sub-module hazard_scoreboard (set port, decrement, freeze, per-source lookup).

Verification
REQ-035 lw r3 issues, next add uses r3 -> exactly 1 stall cycle (bubble=1), stall_cnt=1.
REQ-036 add r4 issues, next beq uses r4 -> 1 stall; lw r4 then beq r4 -> 2 stalls; LOAD_LAT=3 lw then add -> 3 stalls.
REQ-037 lw r0 then add uses r0 -> no stall; unused source matching busy rd -> no stall.
REQ-038 beq taken while stalled -> if_flush=0 until stall clears, then 1 cycle if_flush=1, flush_cnt=1; jump -> immediate flush.
REQ-039 mem_stall held 5 cycles during lw dependency -> all enables 0, bubble 0, stall_cnt unchanged, after release 1 stall remains.
REQ-040 rst asserted mid-load-stall, asynchronously -> scoreboard clear, counters 0, pc_write=1 before next clk edge.

Source files
------------

// File: rtl/pipe_hazard_pkg.sv
// Shared defaults, control-word encoding and wait-counter sizing
// for the pipeline hazard controller.
package pipe_hazard_pkg;

  localparam int REG_AW_DEF      = 5;
  localparam int NUM_SRC_DEF     = 2;
  localparam int LOAD_LAT_DEF    = 1;
  localparam int BR_ALU_WAIT_DEF = 1;
  localparam int CNT_W_DEF       = 16;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_bubble;
    logic if_flush;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_RUN   = '{1'b1, 1'b1, 1'b0, 1'b0};
  localparam hz_ctrl_t CTRL_HOLD  = '{1'b0, 1'b0, 1'b0, 1'b0};
  localparam hz_ctrl_t CTRL_STALL = '{1'b0, 1'b0, 1'b1, 1'b0};
  localparam hz_ctrl_t CTRL_FLUSH = '{1'b1, 1'b1, 1'b0, 1'b1};

  // Wide enough for LOAD_LAT+1; grows only if BR_ALU_WAIT exceeds that.
  function automatic int wait_w(int load_lat, int br_wait);
    int top_v;
    top_v = (load_lat + 1 > br_wait) ? load_lat + 1 : br_wait;
    return $clog2(top_v + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register EX / ID wait counters with set, decrement,
// freeze and per-source busy lookup. Register 0 never reports busy.
module hazard_scoreboard
  import pipe_hazard_pkg::*;
#(
  parameter int REG_AW  = REG_AW_DEF,
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int WW      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      freeze,
  input  logic                      set_en,
  input  logic [REG_AW-1:0]         set_rd,
  input  logic [WW-1:0]             set_ex,
  input  logic [WW-1:0]             set_id,
  input  logic [NUM_SRC*REG_AW-1:0] src,
  output logic [NUM_SRC-1:0]        ex_busy,
  output logic [NUM_SRC-1:0]        id_busy
);

  localparam int NREG = 2 ** REG_AW;

  logic [WW-1:0] ex_wait [NREG];
  logic [WW-1:0] id_wait [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        ex_wait[i] <= '0;
        id_wait[i] <= '0;
      end
    end else if (!freeze) begin
      for (int i = 0; i < NREG; i++) begin
        if (set_en && set_rd == REG_AW'(i)) begin
          ex_wait[i] <= set_ex;
          id_wait[i] <= set_id;
        end else begin
          ex_wait[i] <= (ex_wait[i] != '0) ?
                        ex_wait[i] - WW'(1) : '0;
          id_wait[i] <= (id_wait[i] != '0) ?
                        id_wait[i] - WW'(1) : '0;
        end
      end
    end
  end

  always_comb begin
    ex_busy = '0;
    id_busy = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      ex_busy[s] = (src[s*REG_AW +: REG_AW] != '0) &&
                   (ex_wait[src[s*REG_AW +: REG_AW]] != '0);
      id_busy[s] = (src[s*REG_AW +: REG_AW] != '0) &&
                   (id_wait[src[s*REG_AW +: REG_AW]] != '0);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use / branch-compare hazard detection, control-flow flush
// and stall/flush performance counters for a 5-stage pipeline.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int NUM_SRC     = NUM_SRC_DEF,
  parameter int LOAD_LAT    = LOAD_LAT_DEF,
  parameter int BR_ALU_WAIT = BR_ALU_WAIT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic                      id_is_branch,
  input  logic                      id_br_taken,
  input  logic                      id_jump,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      mem_stall,
  output logic                      pc_write,
  output logic                      if_id_write,
  output logic                      id_ex_bubble,
  output logic                      if_flush,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt
);

  localparam int WW = wait_w(LOAD_LAT, BR_ALU_WAIT);

  logic [NUM_SRC-1:0] ex_busy;
  logic [NUM_SRC-1:0] id_busy;
  logic               hz_stall;
  logic               issue;
  logic               redirect;
  logic               set_en;
  logic [WW-1:0]      set_ex;
  logic [WW-1:0]      set_id;
  logic               sel_rst;
  logic               sel_hold;
  logic               sel_stall;
  logic               sel_flush;
  hz_ctrl_t           ctrl;

  // Branches compare in ID, so they wait on the longer ID window.
  assign hz_stall = id_valid &
                    (|(id_src_used &
                       (id_is_branch ? id_busy : ex_busy)));
  assign issue    = id_valid & ~hz_stall & ~mem_stall;
  assign redirect = issue &
                    (id_jump | (id_is_branch & id_br_taken));
  assign set_en   = issue & id_reg_write & (id_rd != '0);
  assign set_ex   = id_mem_read ? WW'(LOAD_LAT) : '0;
  assign set_id   = id_mem_read ? WW'(LOAD_LAT + 1) :
                                  WW'(BR_ALU_WAIT);

  hazard_scoreboard #(
    .REG_AW  (REG_AW),
    .NUM_SRC (NUM_SRC),
    .WW      (WW)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .freeze  (mem_stall),
    .set_en  (set_en),
    .set_rd  (id_rd),
    .set_ex  (set_ex),
    .set_id  (set_id),
    .src     (id_src),
    .ex_busy (ex_busy),
    .id_busy (id_busy)
  );

  assign sel_rst   = rst;
  assign sel_hold  = ~rst & mem_stall;
  assign sel_stall = ~rst & ~mem_stall & hz_stall;
  assign sel_flush = ~rst & redirect;

  always_comb begin
    ctrl = CTRL_RUN;
    unique case (1'b1)
      sel_rst:   ctrl = CTRL_RUN;
      sel_hold:  ctrl = CTRL_HOLD;
      sel_stall: ctrl = CTRL_STALL;
      sel_flush: ctrl = CTRL_FLUSH;
      default:   ctrl = CTRL_RUN;
    endcase
  end

  assign pc_write     = ctrl.pc_write;
  assign if_id_write  = ctrl.if_id_write;
  assign id_ex_bubble = ctrl.id_ex_bubble;
  assign if_flush     = ctrl.if_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hz_stall && !mem_stall)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
